// File: rtl/rtc_bcd_alarm_if.sv
// rtc_bcd_alarm_if: host-side bundle for the watch time-of-day core.
//   master : the controller (drives mode/set/alarm controls, reads digits)
//   slave  : the rtc_bcd_alarm core
// Signals:
//   i_mode_12h            1 = 12h display, 0 = 24h display
//   i_set_en / i_set_*    load strobe + binary hh:mm:ss
//   i_alm_wr / i_alm_*    alarm load strobe + binary hh:mm
//   i_alm_en              alarm enable level
//   i_alm_snooze/i_alm_ack snooze / dismiss strobes
//   o_*_ones/o_*_tens     registered BCD digits
//   o_pm, o_tick, o_set_err, o_alarm   status outputs
interface rtc_bcd_alarm_if;
    logic       i_mode_12h;
    logic       i_set_en;
    logic [4:0] i_set_hour;
    logic [5:0] i_set_min;
    logic [5:0] i_set_sec;
    logic       i_alm_wr;
    logic [4:0] i_alm_hour;
    logic [5:0] i_alm_min;
    logic       i_alm_en;
    logic       i_alm_snooze;
    logic       i_alm_ack;
    logic [3:0] o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_hour_ones, o_hour_tens;
    logic       o_pm;
    logic       o_tick;
    logic       o_set_err;
    logic       o_alarm;

    modport master (
        output i_mode_12h, i_set_en, i_set_hour, i_set_min, i_set_sec,
               i_alm_wr, i_alm_hour, i_alm_min, i_alm_en, i_alm_snooze, i_alm_ack,
        input  o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_hour_ones, o_hour_tens,
               o_pm, o_tick, o_set_err, o_alarm
    );

    modport slave (
        input  i_mode_12h, i_set_en, i_set_hour, i_set_min, i_set_sec,
               i_alm_wr, i_alm_hour, i_alm_min, i_alm_en, i_alm_snooze, i_alm_ack,
        output o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_hour_ones, o_hour_tens,
               o_pm, o_tick, o_set_err, o_alarm
    );
endinterface

// File: rtl/rtc_bcd_alarm.sv
// rtc_bcd_alarm: BCD hh:mm:ss time-of-day counter with prescaler, 12h/24h
// display, range-checked time/alarm loading and a ring/snooze alarm FSM.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-low reset
//   bus    rtc_bcd_alarm_if.slave (controls in, registered digits/status out)
module rtc_bcd_alarm #(
    parameter int CLK_DIV    = 50000000,
    parameter int ALARM_LEN  = 30,
    parameter int SNOOZE_MIN = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    rtc_bcd_alarm_if.slave  bus
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RING_W = $clog2(ALARM_LEN + 1);
    localparam int SNZ_LD = SNOOZE_MIN * 60;
    localparam int SNZ_W  = $clog2(SNZ_LD + 1);

    typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        bin2bcd = {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    logic [DIV_W-1:0]  r_div;
    logic [3:0]        r_s1, r_s10, r_m1, r_m10, r_h1, r_h10;
    logic [3:0]        w_ns1, w_ns10, w_nm1, w_nm10, w_nh1, w_nh10;
    logic [3:0]        r_am1, r_am10, r_ah1, r_ah10;
    logic              r_adv;
    state_t            r_state, w_state_nxt;
    logic [RING_W-1:0] r_ring, w_ring_nxt;
    logic [SNZ_W-1:0]  r_snz, w_snz_nxt;

    logic w_wrap, w_set_ok, w_set_ld, w_alm_ok, w_alm_ld, w_adv, w_match;
    logic [4:0] w_hbin, w_h12;
    logic [7:0] w_hdisp;

    assign w_wrap   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_set_ok = (bus.i_set_hour <= 5'd23) && (bus.i_set_min <= 6'd59) && (bus.i_set_sec <= 6'd59);
    assign w_set_ld = bus.i_set_en && w_set_ok;
    assign w_alm_ok = (bus.i_alm_hour <= 5'd23) && (bus.i_alm_min <= 6'd59);
    assign w_alm_ld = bus.i_alm_wr && w_alm_ok;
    // A valid load in the same cycle swallows the second-advance.
    assign w_adv    = w_wrap && !w_set_ld;

    // BCD successor of the current time
    always_comb begin
        w_ns1 = r_s1;  w_ns10 = r_s10;
        w_nm1 = r_m1;  w_nm10 = r_m10;
        w_nh1 = r_h1;  w_nh10 = r_h10;
        if (r_s1 != 4'd9) w_ns1 = r_s1 + 4'd1;
        else begin
            w_ns1 = 4'd0;
            if (r_s10 != 4'd5) w_ns10 = r_s10 + 4'd1;
            else begin
                w_ns10 = 4'd0;
                if (r_m1 != 4'd9) w_nm1 = r_m1 + 4'd1;
                else begin
                    w_nm1 = 4'd0;
                    if (r_m10 != 4'd5) w_nm10 = r_m10 + 4'd1;
                    else begin
                        w_nm10 = 4'd0;
                        if (r_h10 == 4'd2 && r_h1 == 4'd3) begin
                            w_nh10 = 4'd0;
                            w_nh1  = 4'd0;
                        end else if (r_h1 == 4'd9) begin
                            w_nh1  = 4'd0;
                            w_nh10 = r_h10 + 4'd1;
                        end else begin
                            w_nh1  = r_h1 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Only a real advance can ring; a load landing on the match time cannot.
    assign w_match = w_adv && bus.i_alm_en &&
                     ({w_nh10, w_nh1, w_nm10, w_nm1, w_ns10, w_ns1} ==
                      {r_ah10, r_ah1, r_am10, r_am1, 8'h00});

    // Prescaler, time and alarm registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div <= '0;
            {r_h10, r_h1, r_m10, r_m1, r_s10, r_s1} <= '0;
            {r_ah10, r_ah1, r_am10, r_am1} <= '0;
            r_adv <= 1'b0;
        end else begin
            r_adv <= w_adv;
            if (w_set_ld || w_wrap) r_div <= '0;
            else                    r_div <= r_div + DIV_W'(1);
            if (w_set_ld) begin
                {r_h10, r_h1} <= bin2bcd({1'b0, bus.i_set_hour});
                {r_m10, r_m1} <= bin2bcd(bus.i_set_min);
                {r_s10, r_s1} <= bin2bcd(bus.i_set_sec);
            end else if (w_adv) begin
                {r_h10, r_h1, r_m10, r_m1, r_s10, r_s1} <=
                    {w_nh10, w_nh1, w_nm10, w_nm1, w_ns10, w_ns1};
            end
            if (w_alm_ld) begin
                {r_ah10, r_ah1} <= bin2bcd({1'b0, bus.i_alm_hour});
                {r_am10, r_am1} <= bin2bcd(bus.i_alm_min);
            end
        end
    end

    // Alarm FSM: state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_ring  <= '0;
            r_snz   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ring  <= w_ring_nxt;
            r_snz   <= w_snz_nxt;
        end
    end

    // Alarm FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring;
        w_snz_nxt   = r_snz;
        if (!bus.i_alm_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_match) begin
                        w_state_nxt = S_RING;
                        w_ring_nxt  = '0;
                    end
                end
                S_RING: begin
                    if (bus.i_alm_ack) begin
                        w_state_nxt = S_IDLE;
                    end else if (bus.i_alm_snooze) begin
                        w_state_nxt = S_SNOOZE;
                        w_snz_nxt   = SNZ_W'(SNZ_LD);
                    end else if (w_adv) begin
                        if (r_ring == RING_W'(ALARM_LEN - 1)) w_state_nxt = S_IDLE;
                        else                                  w_ring_nxt  = r_ring + RING_W'(1);
                    end
                end
                S_SNOOZE: begin
                    if (bus.i_alm_ack) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_adv) begin
                        if (r_snz == SNZ_W'(1)) begin
                            w_state_nxt = S_RING;
                            w_ring_nxt  = '0;
                        end else begin
                            w_snz_nxt = r_snz - SNZ_W'(1);
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Display: 0 -> 12, 13..23 -> hour-12 in 12h mode
    assign w_hbin  = 5'(r_h10) * 5'd10 + 5'(r_h1);
    assign w_h12   = (w_hbin == 5'd0) ? 5'd12 : (w_hbin > 5'd12) ? (w_hbin - 5'd12) : w_hbin;
    assign w_hdisp = bus.i_mode_12h ? bin2bcd({1'b0, w_h12}) : {r_h10, r_h1};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            bus.o_sec_ones  <= '0;
            bus.o_sec_tens  <= '0;
            bus.o_min_ones  <= '0;
            bus.o_min_tens  <= '0;
            bus.o_hour_ones <= '0;
            bus.o_hour_tens <= '0;
            bus.o_pm        <= 1'b0;
            bus.o_tick      <= 1'b0;
            bus.o_set_err   <= 1'b0;
            bus.o_alarm     <= 1'b0;
        end else begin
            bus.o_sec_ones  <= r_s1;
            bus.o_sec_tens  <= r_s10;
            bus.o_min_ones  <= r_m1;
            bus.o_min_tens  <= r_m10;
            bus.o_hour_ones <= w_hdisp[3:0];
            bus.o_hour_tens <= w_hdisp[7:4];
            bus.o_pm        <= (w_hbin >= 5'd12);
            bus.o_tick      <= r_adv;
            bus.o_set_err   <= (bus.i_set_en && !w_set_ok) || (bus.i_alm_wr && !w_alm_ok);
            bus.o_alarm     <= (r_state == S_RING);
        end
    end
endmodule

// File: tb/tb_rtc_bcd_alarm.sv
// tb_rtc_bcd_alarm: directed bench for rtc_bcd_alarm with CLK_DIV=4,
// ALARM_LEN=3, SNOOZE_MIN=1. Expected values are hand-computed constants.
module tb_rtc_bcd_alarm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rtc_bcd_alarm_if u_if();

    rtc_bcd_alarm #(.CLK_DIV(4), .ALARM_LEN(3), .SNOOZE_MIN(1)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if.slave)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] disp();
        return {8'h00, u_if.o_hour_tens, u_if.o_hour_ones, u_if.o_min_tens,
                u_if.o_min_ones, u_if.o_sec_tens, u_if.o_sec_ones};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        u_if.i_set_en   = 1'b1;
        u_if.i_set_hour = 5'(h);
        u_if.i_set_min  = 6'(m);
        u_if.i_set_sec  = 6'(s);
        step(1);
        u_if.i_set_en   = 1'b0;
    endtask

    task automatic alm_write(input int h, input int m);
        u_if.i_alm_wr   = 1'b1;
        u_if.i_alm_hour = 5'(h);
        u_if.i_alm_min  = 6'(m);
        step(1);
        u_if.i_alm_wr   = 1'b0;
    endtask

    task automatic pulse_snooze();
        u_if.i_alm_snooze = 1'b1;
        step(1);
        u_if.i_alm_snooze = 1'b0;
    endtask

    task automatic pulse_ack();
        u_if.i_alm_ack = 1'b1;
        step(1);
        u_if.i_alm_ack = 1'b0;
    endtask

    // Steps until tick is seen; returns cycles taken. Bounded.
    task automatic wait_tick(input string tag, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (u_if.o_tick !== 1'b1 && n < 20);
        if (u_if.o_tick !== 1'b1) chk({tag, "_timeout"}, {31'd0, u_if.o_tick}, 32'd1);
    endtask

    initial begin
        int n;
        int bad;
        u_if.i_mode_12h   = 1'b0;
        u_if.i_set_en     = 1'b0;
        u_if.i_set_hour   = '0;
        u_if.i_set_min    = '0;
        u_if.i_set_sec    = '0;
        u_if.i_alm_wr     = 1'b0;
        u_if.i_alm_hour   = '0;
        u_if.i_alm_min    = '0;
        u_if.i_alm_en     = 1'b0;
        u_if.i_alm_snooze = 1'b0;
        u_if.i_alm_ack    = 1'b0;

        // 1. reset state and 12h display of hour 0
        #12;
        chk("rst_disp",  disp(), 32'h000000);
        chk("rst_alarm", {31'd0, u_if.o_alarm}, 32'd0);
        chk("rst_tick",  {31'd0, u_if.o_tick}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(1);
        chk("rel_disp", disp(), 32'h000000);
        chk("rel_pm",   {31'd0, u_if.o_pm}, 32'd0);
        u_if.i_mode_12h = 1'b1;
        step(1);
        chk("rel_h12", {24'd0, u_if.o_hour_tens, u_if.o_hour_ones}, 32'h12);
        u_if.i_mode_12h = 1'b0;

        // 2. midnight rollover, tick spacing, pm
        set_time(23, 59, 58);
        step(1);
        chk("t2_load", disp(), 32'h235958);
        chk("t2_pm1",  {31'd0, u_if.o_pm}, 32'd1);
        wait_tick("t2_tk1", n);
        chk("t2_gap1", n, 4);
        chk("t2_d1",   disp(), 32'h235959);
        wait_tick("t2_tk2", n);
        chk("t2_gap2", n, 4);
        chk("t2_d2",   disp(), 32'h000000);
        chk("t2_pm0",  {31'd0, u_if.o_pm}, 32'd0);
        step(1);
        chk("t2_tick1cyc", {31'd0, u_if.o_tick}, 32'd0);

        // 3. 12h mapping
        u_if.i_mode_12h = 1'b1;
        set_time(13, 5, 0);
        step(1);
        chk("t3_13h", disp(), 32'h010500);
        chk("t3_pm1", {31'd0, u_if.o_pm}, 32'd1);
        set_time(0, 0, 0);
        step(1);
        chk("t3_0h",  disp(), 32'h120000);
        chk("t3_pm0", {31'd0, u_if.o_pm}, 32'd0);
        u_if.i_mode_12h = 1'b0;

        // 4. rejected load, then load on the advance edge
        set_time(10, 20, 30);
        step(1);
        chk("t4_load", disp(), 32'h102030);
        set_time(10, 60, 30);
        chk("t4_err1", {31'd0, u_if.o_set_err}, 32'd1);
        step(1);
        chk("t4_err0",  {31'd0, u_if.o_set_err}, 32'd0);
        chk("t4_keep",  disp(), 32'h102030);
        set_time(11, 11, 11);          // coincides with the advance edge
        step(1);
        chk("t4_ld2",   disp(), 32'h111111);
        chk("t4_notk",  {31'd0, u_if.o_tick}, 32'd0);
        wait_tick("t4_tk", n);
        chk("t4_gap",   n, 4);
        chk("t4_adv",   disp(), 32'h111112);
        alm_write(24, 0);
        chk("t4_aerr1", {31'd0, u_if.o_set_err}, 32'd1);
        step(1);
        chk("t4_aerr0", {31'd0, u_if.o_set_err}, 32'd0);

        // 5. ring timeout, then snooze / re-ring / ack
        alm_write(7, 30);
        u_if.i_alm_en = 1'b1;
        set_time(7, 29, 59);
        wait_tick("t5_a", n);
        chk("t5_match", disp(), 32'h073000);
        chk("t5_ring",  {31'd0, u_if.o_alarm}, 32'd1);
        wait_tick("t5_b", n);
        chk("t5_ring1", {31'd0, u_if.o_alarm}, 32'd1);
        wait_tick("t5_c", n);
        chk("t5_ring2", {31'd0, u_if.o_alarm}, 32'd1);
        wait_tick("t5_d", n);
        chk("t5_tmo",   {31'd0, u_if.o_alarm}, 32'd0);

        set_time(7, 29, 59);
        wait_tick("t5_e", n);
        chk("t5_ring_b", {31'd0, u_if.o_alarm}, 32'd1);
        pulse_snooze();
        step(1);
        chk("t5_snz", {31'd0, u_if.o_alarm}, 32'd0);
        bad = 0;
        for (int i = 0; i < 59; i++) begin
            wait_tick("t5_s", n);
            if (u_if.o_alarm !== 1'b0) bad++;
        end
        chk("t5_snz_quiet", bad, 0);
        wait_tick("t5_s60", n);
        chk("t5_rering", {31'd0, u_if.o_alarm}, 32'd1);
        pulse_ack();
        step(1);
        chk("t5_ack", {31'd0, u_if.o_alarm}, 32'd0);

        // load onto the match time must not ring
        set_time(7, 30, 0);
        step(2);
        chk("t5_setnoring", {31'd0, u_if.o_alarm}, 32'd0);

        // 6. async reset mid-ring; alm_en drop during snooze
        set_time(7, 29, 59);
        wait_tick("t6_a", n);
        chk("t6_ring", {31'd0, u_if.o_alarm}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_async_alarm", {31'd0, u_if.o_alarm}, 32'd0);
        chk("t6_async_disp",  disp(), 32'h000000);
        @(posedge clk); #1;
        rst = 1'b1;
        alm_write(7, 30);
        set_time(7, 29, 59);
        wait_tick("t6_b", n);
        chk("t6_ring2", {31'd0, u_if.o_alarm}, 32'd1);
        pulse_snooze();
        step(1);
        chk("t6_snz", {31'd0, u_if.o_alarm}, 32'd0);
        u_if.i_alm_en = 1'b0;
        step(2);
        u_if.i_alm_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 61; i++) begin
            wait_tick("t6_s", n);
            if (u_if.o_alarm !== 1'b0) bad++;
        end
        chk("t6_no_rering", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
